// File: rtl/bcm_channel_driver.sv
// ---------------------------------------------------------------------------
// bcm_channel_driver
//
// Binary-code-modulation channel driver. Consumes the free-running 8-bit BCM
// time-slot pointer and drives NUM_CH LED outputs from per-channel 8-bit
// brightness values. Brightness writes land in a shadow bank that is copied
// to the active bank only on the address == 0 slot. A frame therefore never
// shows a mix of old and new brightness values.
//
// Slot-to-plane mapping: plane = floor(log2(address+1)) for address 0..254.
// Plane k is lit for 2^k slots. Address 255 is the blank slot.
//
// Optional build macro:
//   BCM_SYNC_CHECK_EN  When defined, every sampled address in RUN is checked
//                      against (previous address + 1) mod 256. A mismatch
//                      sets the sticky sync_err flag and drops the FSM back
//                      to SYNC. When undefined, sync_err is tied to 0 and
//                      RUN is left only by reset.
//
// Parameters:
//   NUM_CH  number of LED channels (1..32)
//   CH_W    width of load_ch, at least ceil(log2(NUM_CH)), minimum 1
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   address      BCM time-slot pointer, +1 per clk, wraps 255->0
//   load_valid   brightness write request
//   load_ready   write accepted when load_valid && load_ready (comb.)
//   load_ch      target channel; indices >= NUM_CH are accepted and dropped
//   load_data    brightness value for load_ch
//   led_out      BCM-modulated channel outputs (registered)
//   bitplane     plane index currently driven (registered)
//   blank        high on the blank slot or while not synchronised (reg.)
//   frame_start  one-cycle pulse aligned with the output for address 0
//   sync_err     sticky pointer-discontinuity flag
// ---------------------------------------------------------------------------
module bcm_channel_driver #(
    parameter int NUM_CH = 8,
    parameter int CH_W   = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        address,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [CH_W-1:0]   load_ch,
    input  logic [7:0]        load_data,
    output logic [NUM_CH-1:0] led_out,
    output logic [2:0]        bitplane,
    output logic              blank,
    output logic              frame_start,
    output logic              sync_err
);

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Plane index for a slot. Thresholds are the first slot of each plane
    // (2^k - 1); address 255 falls into the last bucket, so the blank slot
    // reports plane 7 without a special case.
    function automatic logic [2:0] plane_decode(input logic [7:0] a);
        logic [2:0] p;
        p = 3'd0;
        if (a >= 8'd1)   p = 3'd1;
        if (a >= 8'd3)   p = 3'd2;
        if (a >= 8'd7)   p = 3'd3;
        if (a >= 8'd15)  p = 3'd4;
        if (a >= 8'd31)  p = 3'd5;
        if (a >= 8'd63)  p = 3'd6;
        if (a >= 8'd127) p = 3'd7;
        return p;
    endfunction

    state_t            state_p1;
    logic [7:0]        shadow_q   [NUM_CH];
    logic [7:0]        active_q   [NUM_CH];
    logic [7:0]        active_nxt [NUM_CH];

    logic              swap_p0;
    logic              blank_slot_p0;
    logic [2:0]        plane_p0;
    logic              wr_en_p0;
    logic              mismatch_p0;
    logic              vld_p0;
    logic [NUM_CH-1:0] led_nxt_p0;

    // ---- stage p0: combinational decode of the sampled pointer ----
    assign swap_p0       = (address == 8'd0);
    assign blank_slot_p0 = (address == 8'hFF);
    assign plane_p0      = plane_decode(address);

    // The swap slot never accepts a write, so the copy cannot race a write.
    assign load_ready = (address != 8'd0) && rst_n;
    assign wr_en_p0   = load_valid && load_ready;

`ifdef BCM_SYNC_CHECK_EN
    logic [7:0] prev_addr_p1;
    logic       sync_err_p1;

    // 8-bit compare context makes prev + 1 wrap 255 -> 0 naturally.
    assign mismatch_p0 = (state_p1 == RUN) && (address != prev_addr_p1 + 8'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_addr_p1 <= 8'd0;
            sync_err_p1  <= 1'b0;
        end else begin
            prev_addr_p1 <= address;
            if (mismatch_p0) begin
                sync_err_p1 <= 1'b1;
            end
        end
    end

    assign sync_err = sync_err_p1;
`else
    assign mismatch_p0 = 1'b0;
    assign sync_err    = 1'b0;
`endif

    // A live output cycle: either steady RUN with a continuous pointer, or
    // the address-0 slot, which (re)enters RUN from SYNC on the same cycle.
    assign vld_p0 = swap_p0 || ((state_p1 == RUN) && !mismatch_p0);

    // Bypass of the bank copy: the swap slot already displays the new values.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            active_nxt[i] = swap_p0 ? shadow_q[i] : active_q[i];
        end
    end

    always_comb begin
        led_nxt_p0 = '0;
        if (vld_p0 && !blank_slot_p0) begin
            for (int i = 0; i < NUM_CH; i++) begin
                led_nxt_p0[i] = active_nxt[i][plane_p0];
            end
        end
    end

    // ---- stage p1: brightness banks ----
    // Channel indices at or above NUM_CH match no entry, so such writes
    // complete the handshake and are silently dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow_q[i] <= 8'd0;
                active_q[i] <= 8'd0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_en_p0 && (load_ch == CH_W'(i))) begin
                    shadow_q[i] <= load_data;
                end
                if (swap_p0) begin
                    active_q[i] <= shadow_q[i];
                end
            end
        end
    end

    // ---- stage p1: FSM and registered outputs ----
    // bitplane holds its last value while not synchronised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1    <= SYNC;
            led_out     <= '0;
            bitplane    <= 3'd0;
            blank       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            state_p1    <= vld_p0 ? RUN : SYNC;
            led_out     <= led_nxt_p0;
            blank       <= !vld_p0 || blank_slot_p0;
            frame_start <= vld_p0 && swap_p0;
            if (vld_p0) begin
                bitplane <= plane_p0;
            end
        end
    end

endmodule
